// File: rtl/dbscan_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dbscan_pkg
// Description : Shared constants for the DBSCAN point store: FSM state
//               encoding and the reserved "unclassified" label value.
// Revision    : 1.0 - initial release
// ============================================================================
package dbscan_pkg;

  // FSM state encoding shared by the store and anything that decodes it
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] CLEAR = 2'd1;
  localparam logic [STATE_W-1:0] LOAD  = 2'd2;
  localparam logic [STATE_W-1:0] READY = 2'd3;

  // Label value meaning "not yet assigned to a cluster"
  localparam int unsigned LABEL_UNCLASSIFIED = 0;

endpackage : dbscan_pkg
`default_nettype wire

// File: rtl/dbscan_point_store_if.sv
`default_nettype none
// ============================================================================
// Interface   : dbscan_point_store_if
// Description : Control, point-stream, read-port and label-write bundle of
//               the DBSCAN point store. slave = store side, master = user.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbscan_point_store_if #(
  parameter int N  = 16,
  parameter int CW = 8,
  parameter int LW = 4,
  parameter int AW = $clog2(N)
);

  // control
  logic          load_start;
  logic          rescan;
  // point stream
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic [CW-1:0] in_z;
  logic          in_last;
  // status
  logic [AW:0]   count;
  logic          busy;
  logic          ready;
  logic          overflow;
  // read ports
  logic [AW-1:0] raddr_i;
  logic [AW-1:0] raddr_j;
  logic [CW-1:0] xi, yi, zi;
  logic [CW-1:0] xj, yj, zj;
  logic [LW-1:0] li, lj;
  logic          core_i, core_j;
  logic          vld_i, vld_j;
  // label/core write port
  logic          we_label;
  logic          we_core;
  logic [AW-1:0] waddr;
  logic [LW-1:0] wlabel;
  logic          wcore;

  modport slave (
    input  load_start, rescan,
    input  in_valid, in_x, in_y, in_z, in_last,
    output in_ready,
    output count, busy, ready, overflow,
    input  raddr_i, raddr_j,
    output xi, yi, zi, xj, yj, zj, li, lj, core_i, core_j, vld_i, vld_j,
    input  we_label, we_core, waddr, wlabel, wcore
  );

  modport master (
    output load_start, rescan,
    output in_valid, in_x, in_y, in_z, in_last,
    input  in_ready,
    input  count, busy, ready, overflow,
    output raddr_i, raddr_j,
    input  xi, yi, zi, xj, yj, zj, li, lj, core_i, core_j, vld_i, vld_j,
    output we_label, we_core, waddr, wlabel, wcore
  );

endinterface : dbscan_point_store_if
`default_nettype wire

// File: rtl/dbscan_label_ram.sv
`default_nettype none
// ============================================================================
// Module      : dbscan_label_ram
// Description : N x (label + core) register array. One write port with
//               independent label/core enables, two registered read ports
//               with write-first forwarding; a read whose valid is low
//               registers zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module dbscan_label_ram #(
  parameter int N  = 16,
  parameter int LW = 4,
  parameter int AW = $clog2(N)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_we_label,
  input  wire logic          i_we_core,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [LW-1:0] i_wlabel,
  input  wire logic          i_wcore,
  input  wire logic [AW-1:0] i_raddr_i,
  input  wire logic [AW-1:0] i_raddr_j,
  input  wire logic          i_rvld_i,
  input  wire logic          i_rvld_j,
  output logic      [LW-1:0] o_li,
  output logic      [LW-1:0] o_lj,
  output logic               o_core_i,
  output logic               o_core_j
);

  logic [LW-1:0] r_label [N];
  logic          r_core  [N];

  logic [LW-1:0] w_li, w_lj;
  logic          w_ci, w_cj;

  // Array storage: label and core fields are written independently
  always_ff @(posedge clk) begin
    if (i_we_label) r_label[i_waddr] <= i_wlabel;
    if (i_we_core)  r_core[i_waddr]  <= i_wcore;
  end

  // Write-first forwarding: a same-cycle write to the read address wins
  always_comb begin
    w_li = r_label[i_raddr_i];
    w_lj = r_label[i_raddr_j];
    w_ci = r_core[i_raddr_i];
    w_cj = r_core[i_raddr_j];
    if (i_we_label && (i_waddr == i_raddr_i)) w_li = i_wlabel;
    if (i_we_label && (i_waddr == i_raddr_j)) w_lj = i_wlabel;
    if (i_we_core  && (i_waddr == i_raddr_i)) w_ci = i_wcore;
    if (i_we_core  && (i_waddr == i_raddr_j)) w_cj = i_wcore;
  end

  // Registered read outputs, zeroed when the address is beyond count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_li     <= '0;
      o_lj     <= '0;
      o_core_i <= 1'b0;
      o_core_j <= 1'b0;
    end else begin
      o_li     <= i_rvld_i ? w_li : '0;
      o_lj     <= i_rvld_j ? w_lj : '0;
      o_core_i <= i_rvld_i & w_ci;
      o_core_j <= i_rvld_j & w_cj;
    end
  end

endmodule : dbscan_label_ram
`default_nettype wire

// File: rtl/dbscan_point_store.sv
`default_nettype none
// ============================================================================
// Module      : dbscan_point_store
// Description : Point store for the DBSCAN core. Loads up to N 3-D points
//               from a valid/ready stream, serves two registered read ports
//               and clears labels/core flags with an N-cycle sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module dbscan_point_store
  import dbscan_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 8,
  parameter int LW = 4,
  parameter int AW = $clog2(N)
) (
  input wire logic           clk,
  input wire logic           rst_n,
  dbscan_point_store_if.slave bus
);

  localparam logic [AW:0]   c_cap  = (AW+1)'(N);
  localparam logic [AW-1:0] c_last = AW'(N - 1);
  localparam logic [LW-1:0] c_lbl0 = LW'(LABEL_UNCLASSIFIED);

  logic [STATE_W-1:0] r_state;
  logic [AW:0]        r_count;
  logic               r_overflow;
  logic               r_load_after;
  logic [AW-1:0]      r_clr_ptr;

  logic [CW-1:0] r_x [N];
  logic [CW-1:0] r_y [N];
  logic [CW-1:0] r_z [N];

  logic          w_in_ready, w_hs, w_full_offer, w_ctrl, w_wr_ok;
  logic          w_vld_i, w_vld_j;
  logic          w_ram_we_label, w_ram_we_core, w_ram_wcore;
  logic [AW-1:0] w_ram_waddr;
  logic [LW-1:0] w_ram_wlabel;

  assign w_in_ready   = (r_state == LOAD) && (r_count < c_cap);
  assign w_hs         = bus.in_valid && w_in_ready;
  assign w_full_offer = (r_state == LOAD) && bus.in_valid && (r_count == c_cap);
  assign w_ctrl       = bus.load_start || bus.rescan;
  // A control pulse in READY drops any write issued in the same cycle
  assign w_wr_ok      = (r_state == READY) && !w_ctrl && ({1'b0, bus.waddr} < r_count);
  assign w_vld_i      = {1'b0, bus.raddr_i} < r_count;
  assign w_vld_j      = {1'b0, bus.raddr_j} < r_count;

  assign bus.in_ready = w_in_ready;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state == CLEAR) || (r_state == LOAD);
  assign bus.ready    = (r_state == READY);

  // Label RAM write mux: the clear sweep owns the port while in CLEAR
  always_comb begin
    w_ram_we_label = bus.we_label && w_wr_ok;
    w_ram_we_core  = bus.we_core  && w_wr_ok;
    w_ram_waddr    = bus.waddr;
    w_ram_wlabel   = bus.wlabel;
    w_ram_wcore    = bus.wcore;
    if (r_state == CLEAR) begin
      w_ram_we_label = 1'b1;
      w_ram_we_core  = 1'b1;
      w_ram_waddr    = r_clr_ptr;
      w_ram_wlabel   = c_lbl0;
      w_ram_wcore    = 1'b0;
    end
  end

  // Control FSM, point counter, overflow flag and clear pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_load_after <= 1'b0;
      r_clr_ptr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load_start) begin
            r_state      <= CLEAR;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_load_after <= 1'b1;
            r_clr_ptr    <= '0;
          end
        end
        CLEAR: begin
          if (r_clr_ptr == c_last) begin
            r_state   <= r_load_after ? LOAD : READY;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_count <= r_count + 1'b1;
            if (bus.in_last) r_state <= READY;
          end else if (w_full_offer) begin
            r_overflow <= 1'b1;
            if (bus.in_last) r_state <= READY;
          end
        end
        READY: begin
          if (bus.load_start) begin
            r_state      <= CLEAR;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_load_after <= 1'b1;
            r_clr_ptr    <= '0;
          end else if (bus.rescan) begin
            r_state      <= CLEAR;
            r_load_after <= 1'b0;
            r_clr_ptr    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Coordinate storage: accepted points are appended at address count
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_x[r_count[AW-1:0]] <= bus.in_x;
      r_y[r_count[AW-1:0]] <= bus.in_y;
      r_z[r_count[AW-1:0]] <= bus.in_z;
    end
  end

  // Registered coordinate reads and valid flags for both ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.xi    <= '0;
      bus.yi    <= '0;
      bus.zi    <= '0;
      bus.xj    <= '0;
      bus.yj    <= '0;
      bus.zj    <= '0;
      bus.vld_i <= 1'b0;
      bus.vld_j <= 1'b0;
    end else begin
      bus.xi    <= w_vld_i ? r_x[bus.raddr_i] : '0;
      bus.yi    <= w_vld_i ? r_y[bus.raddr_i] : '0;
      bus.zi    <= w_vld_i ? r_z[bus.raddr_i] : '0;
      bus.xj    <= w_vld_j ? r_x[bus.raddr_j] : '0;
      bus.yj    <= w_vld_j ? r_y[bus.raddr_j] : '0;
      bus.zj    <= w_vld_j ? r_z[bus.raddr_j] : '0;
      bus.vld_i <= w_vld_i;
      bus.vld_j <= w_vld_j;
    end
  end

  dbscan_label_ram #(
    .N  (N),
    .LW (LW),
    .AW (AW)
  ) u_label_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we_label (w_ram_we_label),
    .i_we_core  (w_ram_we_core),
    .i_waddr    (w_ram_waddr),
    .i_wlabel   (w_ram_wlabel),
    .i_wcore    (w_ram_wcore),
    .i_raddr_i  (bus.raddr_i),
    .i_raddr_j  (bus.raddr_j),
    .i_rvld_i   (w_vld_i),
    .i_rvld_j   (w_vld_j),
    .o_li       (bus.li),
    .o_lj       (bus.lj),
    .o_core_i   (bus.core_i),
    .o_core_j   (bus.core_j)
  );

endmodule : dbscan_point_store
`default_nettype wire

// File: tb/tb_dbscan_point_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbscan_point_store
// Description : Self-checking bench for dbscan_point_store (N=16, CW=8, LW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbscan_point_store;

  localparam int N  = 16;
  localparam int CW = 8;
  localparam int LW = 4;
  localparam int AW = 4;

  logic clk;
  logic rst_n;

  dbscan_point_store_if #(.N(N), .CW(CW), .LW(LW), .AW(AW)) bus ();

  dbscan_point_store #(.N(N), .CW(CW), .LW(LW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x, y, z;
    logic [LW-1:0] l;
    logic          c;
    logic          v;
  } port_t;

  typedef struct {
    string tag;
    port_t pi;
    port_t pj;
  } exp_t;

  typedef struct {
    logic [AW-1:0] ri, rj;
    logic          wl, wc;
    logic [AW-1:0] wa;
    logic [LW-1:0] wlab;
    logic          wcor;
    logic          e_vi, e_ci, e_vj, e_cj;
    logic [LW-1:0] e_li, e_lj;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference model
  logic [CW-1:0] mx [N];
  logic [CW-1:0] my [N];
  logic [CW-1:0] mz [N];
  logic [LW-1:0] ml [N];
  logic          mc [N];
  int            mcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic port_t model_port(input int a);
    port_t p;
    p.v = (a < mcount);
    p.x = p.v ? mx[a] : '0;
    p.y = p.v ? my[a] : '0;
    p.z = p.v ? mz[a] : '0;
    p.l = p.v ? ml[a] : '0;
    p.c = p.v ? mc[a] : 1'b0;
    return p;
  endfunction

  task automatic cmp_port(input string tag, input port_t e, input port_t a);
    chk({tag, ".vld"}, 32'(a.v), 32'(e.v));
    chk({tag, ".x"}, 32'(a.x), 32'(e.x));
    chk({tag, ".y"}, 32'(a.y), 32'(e.y));
    chk({tag, ".z"}, 32'(a.z), 32'(e.z));
    chk({tag, ".label"}, 32'(a.l), 32'(e.l));
    chk({tag, ".core"}, 32'(a.c), 32'(e.c));
  endtask

  // advance one edge and compare the DUT read ports with the oldest expectation
  task automatic pop_and_check();
    exp_t  e;
    port_t ai, aj;
    step();
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      ai.x = bus.xi; ai.y = bus.yi; ai.z = bus.zi;
      ai.l = bus.li; ai.c = bus.core_i; ai.v = bus.vld_i;
      aj.x = bus.xj; aj.y = bus.yj; aj.z = bus.zj;
      aj.l = bus.lj; aj.c = bus.core_j; aj.v = bus.vld_j;
      cmp_port({e.tag, ".i"}, e.pi, ai);
      cmp_port({e.tag, ".j"}, e.pj, aj);
    end
  endtask

  task automatic rd2(input string tag, input int ai, input int aj);
    exp_t e;
    bus.raddr_i = AW'(ai);
    bus.raddr_j = AW'(aj);
    e.tag = tag;
    e.pi  = model_port(ai);
    e.pj  = model_port(aj);
    sb.push_back(e);
    pop_and_check();
  endtask

  // stream cnt points; the model accepts while it holds fewer than N
  task automatic load_points(input int cnt, input int base, input bit with_last);
    for (int k = 0; k < cnt; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x = CW'(base + k * 3 + 1);
      bus.in_y = CW'(base + k * 5 + 2);
      bus.in_z = CW'(200 - base - k);
      bus.in_last = with_last && (k == cnt - 1);
      if (k == N) chk("in_ready_low_when_full", 32'(bus.in_ready), 32'd0);
      if (mcount < N) begin
        mx[mcount] = bus.in_x;
        my[mcount] = bus.in_y;
        mz[mcount] = bus.in_z;
        mcount++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic clear_model_labels();
    for (int k = 0; k < N; k++) begin
      ml[k] = '0;
      mc[k] = 1'b0;
    end
  endtask

  // cycles until cond_sel becomes true: 0 = in_ready, 1 = ready
  task automatic wait_cycles(input int cond_sel, output int n);
    n = 0;
    while (((cond_sel == 0) ? !bus.in_ready : !bus.ready) && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n;

    vecs[0] = '{ri:2, rj:1, wl:1, wc:0, wa:2, wlab:3,  wcor:0, e_vi:1, e_ci:0, e_vj:1, e_cj:0, e_li:3,  e_lj:0};
    vecs[1] = '{ri:9, rj:2, wl:1, wc:0, wa:9, wlab:7,  wcor:0, e_vi:0, e_ci:0, e_vj:1, e_cj:0, e_li:0,  e_lj:3};
    vecs[2] = '{ri:4, rj:5, wl:0, wc:1, wa:4, wlab:0,  wcor:1, e_vi:1, e_ci:1, e_vj:0, e_cj:0, e_li:0,  e_lj:0};
    vecs[3] = '{ri:4, rj:3, wl:0, wc:0, wa:0, wlab:0,  wcor:0, e_vi:1, e_ci:1, e_vj:1, e_cj:0, e_li:0,  e_lj:0};
    vecs[4] = '{ri:1, rj:1, wl:1, wc:1, wa:1, wlab:15, wcor:1, e_vi:1, e_ci:1, e_vj:1, e_cj:1, e_li:15, e_lj:15};
    vecs[5] = '{ri:0, rj:15, wl:1, wc:0, wa:5, wlab:9, wcor:0, e_vi:1, e_ci:0, e_vj:0, e_cj:0, e_li:0,  e_lj:0};
    vecs[6] = '{ri:5, rj:2, wl:0, wc:0, wa:0, wlab:0,  wcor:0, e_vi:0, e_ci:0, e_vj:1, e_cj:0, e_li:0,  e_lj:3};
    vecs[7] = '{ri:4, rj:1, wl:1, wc:0, wa:4, wlab:2,  wcor:0, e_vi:1, e_ci:1, e_vj:1, e_cj:1, e_li:2,  e_lj:15};

    rst_n = 1'b0;
    bus.load_start = 0; bus.rescan = 0;
    bus.in_valid = 0; bus.in_last = 0;
    bus.in_x = 0; bus.in_y = 0; bus.in_z = 0;
    bus.raddr_i = 0; bus.raddr_j = 0;
    bus.we_label = 0; bus.we_core = 0; bus.waddr = 0; bus.wlabel = 0; bus.wcore = 0;
    clear_model_labels();
    for (int k = 0; k < N; k++) begin
      mx[k] = '0; my[k] = '0; mz[k] = '0;
    end

    // reset state
    repeat (3) step();
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.ready", 32'(bus.ready), 0);
    chk("rst.in_ready", 32'(bus.in_ready), 0);
    chk("rst.overflow", 32'(bus.overflow), 0);
    chk("rst.vld_i", 32'(bus.vld_i), 0);
    rst_n = 1'b1;
    step();

    // load 5 points after a 16-cycle clear
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("load1.busy", 32'(bus.busy), 1);
    wait_cycles(0, n);
    chk("load1.clear_cycles", 32'(n), 16);
    load_points(5, 0, 1'b1);
    chk("load1.count", 32'(bus.count), 5);
    chk("load1.ready", 32'(bus.ready), 1);
    chk("load1.busy_after", 32'(bus.busy), 0);
    chk("load1.in_ready_after", 32'(bus.in_ready), 0);
    rd2("rd_4_5", 4, 5);
    rd2("rd_0_3", 0, 3);

    // table of read/write vectors in READY
    for (int t = 0; t < 8; t++) begin
      exp_t e;
      bus.raddr_i  = vecs[t].ri;
      bus.raddr_j  = vecs[t].rj;
      bus.we_label = vecs[t].wl;
      bus.we_core  = vecs[t].wc;
      bus.waddr    = vecs[t].wa;
      bus.wlabel   = vecs[t].wlab;
      bus.wcore    = vecs[t].wcor;
      e.tag = $sformatf("vec%0d", t);
      e.pi  = model_port(int'(vecs[t].ri));
      e.pj  = model_port(int'(vecs[t].rj));
      e.pi.l = vecs[t].e_li; e.pi.c = vecs[t].e_ci; e.pi.v = vecs[t].e_vi;
      e.pj.l = vecs[t].e_lj; e.pj.c = vecs[t].e_cj; e.pj.v = vecs[t].e_vj;
      sb.push_back(e);
      if (int'(vecs[t].wa) < mcount) begin
        if (vecs[t].wl) ml[vecs[t].wa] = vecs[t].wlab;
        if (vecs[t].wc) mc[vecs[t].wa] = vecs[t].wcor;
      end
      pop_and_check();
      bus.we_label = 0;
      bus.we_core  = 0;
    end
    rd2("post_table_1_2", 1, 2);

    // rescan: ready low for N cycles, labels cleared, points kept
    bus.rescan = 1'b1;
    step();
    bus.rescan = 1'b0;
    wait_cycles(1, n);
    chk("rescan.ready_low_cycles", 32'(n), 16);
    chk("rescan.count", 32'(bus.count), 5);
    clear_model_labels();
    for (int k = 0; k < 5; k++) rd2($sformatf("rescan_rd%0d", k), k, 4 - k);

    // simultaneous load_start and rescan: load wins
    bus.load_start = 1'b1;
    bus.rescan     = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.rescan     = 1'b0;
    mcount = 0;
    clear_model_labels();
    chk("both.count", 32'(bus.count), 0);
    chk("both.busy", 32'(bus.busy), 1);
    wait_cycles(0, n);
    chk("both.enters_load_cycles", 32'(n), 16);

    // 17 points into a 16-entry store
    load_points(17, 50, 1'b1);
    chk("ovf.overflow", 32'(bus.overflow), 1);
    chk("ovf.count", 32'(bus.count), 16);
    chk("ovf.ready", 32'(bus.ready), 1);
    rd2("ovf_rd_15_0", 15, 0);

    // load_start from READY clears count and overflow
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    mcount = 0;
    chk("reload.overflow", 32'(bus.overflow), 0);
    chk("reload.count", 32'(bus.count), 0);
    wait_cycles(0, n);
    chk("reload.clear_cycles", 32'(n), 16);
    load_points(2, 90, 1'b0);
    rd2("reload_rd_0_1", 0, 1);

    // asynchronous reset in the middle of LOAD
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("areset.count", 32'(bus.count), 0);
    chk("areset.busy", 32'(bus.busy), 0);
    chk("areset.in_ready", 32'(bus.in_ready), 0);
    chk("areset.xi", 32'(bus.xi), 0);
    chk("areset.vld_i", 32'(bus.vld_i), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle.busy", 32'(bus.busy), 0);
    chk("idle.ready", 32'(bus.ready), 0);
    chk("idle.count", 32'(bus.count), 0);
    bus.in_valid = 1'b0;
    bus.rescan = 1'b1;
    step();
    bus.rescan = 1'b0;
    chk("idle.rescan_ignored", 32'(bus.busy), 0);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("idle.load_start_resumes", 32'(bus.busy), 1);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dbscan_point_store
`default_nettype wire
